screen_sequencer: RTL and testbench
===================================

# screen_sequencer

Top-level screen sequencer for the TicTacToe VGA path. It drives the presentation-screen and winner-screen enables consumed by the screen decoder, gates the game logic, and issues a one-cycle board-clear pulse before every match. It is a Moore FSM with a frame-based hold timer, and sits between the button/game-logic domain and the screen decoder.

## Interface
Parameters:
- WIN_HOLD_FRAMES, default 300: frames the winner screen is held before returning to presentation. Legal range 1..1023.

Ports:
- clk  in  1  system pixel-domain clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per VGA frame, from vsync.
- start_btn  in  1  start button level, already synchronized and debounced.
- game_over  in  1  level from game logic; high when the match has ended.
- winner  in  2  match result, valid while game_over=1: 01 = X, 10 = O, 11 = draw, 00 = none.
- cePS  out  1  presentation screen enable.
- ceSS  out  1  winner screen enable.
- game_en  out  1  game logic enable.
- game_clear  out  1  one-cycle board/score clear pulse.
- winner_latched  out  2  result captured at end of match; feeds the winner screen.
- state  out  2  current FSM state, for debug.

## Operation
- States and encoding:
  - PRESENT = 00: cePS=1, ceSS=0, game_en=0, game_clear=0.
  - CLEAR = 01: all enables 0, game_clear=1.
  - PLAY = 10: game_en=1, cePS=0, ceSS=0.
  - WIN = 11: ceSS=1, cePS=0, game_en=0.
- Outputs decode from the registered state only. cePS and ceSS are never high together.
- Start edge detection:
  - start_rise = start_btn & ~btn_q, where btn_q is the previous-cycle start_btn.
  - btn_q resets to 1, so a button held through reset does not start a game.
- Transitions:
  - PRESENT -> CLEAR on start_rise.
  - CLEAR -> PLAY unconditionally after 1 cycle.
  - PLAY -> WIN when game_over=1. On that same edge, winner_latched <= winner and hold_cnt <= 0.
  - WIN, on start_rise: -> CLEAR (rematch). This has priority over timer expiry in the same cycle.
  - WIN, on frame_tick with hold_cnt == WIN_HOLD_FRAMES-1: -> PRESENT.
  - WIN, otherwise on frame_tick: hold_cnt increments.
- hold_cnt is 10 bits wide, unsigned, and only counts in WIN. It cannot wrap because of the range limit on WIN_HOLD_FRAMES.
- winner_latched:
  - Cleared to 00 on entry to CLEAR.
  - Holds its value through WIN and PRESENT until the next CLEAR.
- Ignored inputs:
  - game_over in PRESENT, CLEAR and WIN.
  - start_rise in CLEAR and PLAY.

## Timing
- Reset (asynchronous assertion, any time including mid-match) forces:
  - state = PRESENT, cePS=1, ceSS=0, game_en=0, game_clear=0.
  - winner_latched=00, hold_cnt=0, btn_q=1.
- After reset deasserts, the first state change can occur on the second rising edge at the earliest (btn_q must first see 0).
- Start latency: start_rise sampled at edge N -> game_clear high for exactly cycle N..N+1 -> game_en high from edge N+1.
- End latency: game_over sampled high at edge M -> ceSS=1 and winner_latched valid from edge M.
- Winner hold: exactly WIN_HOLD_FRAMES frame_tick pulses are seen in WIN, including a tick coincident with the entry edge only if it arrives after it. The return to PRESENT happens on the edge that samples the final tick.
- frame_tick arriving in the same cycle as the PLAY->WIN transition is not counted.

## Test plan
- Reset with start_btn held high, then release and press again -> stays PRESENT (cePS=1) until the second press. Then game_clear is high for 1 cycle and the state goes 01 -> 10 with game_en=1.
- In PLAY, assert game_over=1 with winner=10 -> next cycle state=11, ceSS=1, cePS=0, game_en=0, winner_latched=10.
- WIN_HOLD_FRAMES=3: in WIN, send 3 frame_tick pulses -> state=00 and cePS=1 on the edge sampling the 3rd tick. After 2 ticks it is still WIN.
- In WIN, assert start_rise and the final frame_tick in the same cycle -> next state CLEAR (01), winner_latched=00, then PLAY.
- Assert reset_n=0 asynchronously mid-PLAY (between edges) -> outputs immediately read cePS=1, game_en=0, state=00, winner_latched=00.
- Over a random run of start/game_over/frame_tick stimulus: cePS&ceSS is never 1, and game_clear is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/screen_sequencer.sv
// screen_sequencer
//   Moore FSM that selects the presentation or winner screen, enables the
//   game logic and emits a one-cycle board-clear pulse before every match.
//   The winner screen is held for WIN_HOLD_FRAMES frame ticks and then
//   returns to presentation.
//
// Ports
//   clk            rising-edge pixel-domain clock
//   reset_n        asynchronous active-low reset
//   frame_tick     one-cycle pulse per VGA frame
//   start_btn      synchronized, debounced start button level
//   game_over      match finished (level)
//   winner         match result, valid while game_over=1
//   cePS           presentation screen enable
//   ceSS           winner screen enable
//   game_en        game logic enable
//   game_clear     one-cycle board/score clear
//   winner_latched result captured at end of match
//   state          current FSM state (debug)
module screen_sequencer #(
  parameter int unsigned WIN_HOLD_FRAMES = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic [1:0] winner,
  output logic       cePS,
  output logic       ceSS,
  output logic       game_en,
  output logic       game_clear,
  output logic [1:0] winner_latched,
  output logic [1:0] state
);

  localparam logic [1:0] ST_PRESENT = 2'b00;
  localparam logic [1:0] ST_CLEAR   = 2'b01;
  localparam logic [1:0] ST_PLAY    = 2'b10;
  localparam logic [1:0] ST_WIN     = 2'b11;

  localparam logic [9:0] HOLD_LAST = 10'(WIN_HOLD_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] hold_q, hold_d;
  logic [1:0] win_q, win_d;
  logic       btn_q;
  logic       start_rise;

  // btn_q resets high so a button held through reset is not seen as a press.
  assign start_rise = start_btn & ~btn_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    win_d   = win_q;
    case (state_q)
      ST_PRESENT: begin
        if (start_rise) begin
          state_d = ST_CLEAR;
          win_d   = '0;
        end
      end
      ST_CLEAR: begin
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (game_over) begin
          state_d = ST_WIN;
          win_d   = winner;
          hold_d  = '0;
        end
      end
      ST_WIN: begin
        // A rematch request wins over timer expiry in the same cycle.
        if (start_rise) begin
          state_d = ST_CLEAR;
          win_d   = '0;
        end else if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_PRESENT;
          end else begin
            hold_d = hold_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = ST_PRESENT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_PRESENT;
      hold_q  <= '0;
      win_q   <= '0;
      btn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      btn_q   <= start_btn;
    end
  end

  assign cePS           = (state_q == ST_PRESENT);
  assign ceSS           = (state_q == ST_WIN);
  assign game_en        = (state_q == ST_PLAY);
  assign game_clear     = (state_q == ST_CLEAR);
  assign winner_latched = win_q;
  assign state          = state_q;

endmodule

// File: tb/tb_screen_sequencer.sv
module tb_screen_sequencer;

  localparam int unsigned HOLD = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b1;
  logic       game_over = 1'b0;
  logic [1:0] winner = 2'b00;
  logic       cePS, ceSS, game_en, game_clear;
  logic [1:0] winner_latched, state;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model: screen name as int (0 present, 1 clear, 2 play, 3 win),
  // previous button level, latched result, ticks seen since entering WIN.
  int         m_screen = 0;
  logic       m_prev_btn = 1'b1;
  logic [1:0] m_win = 2'b00;
  int         m_ticks = 0;
  logic       prev_gc = 1'b0;

  screen_sequencer #(.WIN_HOLD_FRAMES(HOLD)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_tick     (frame_tick),
    .start_btn      (start_btn),
    .game_over      (game_over),
    .winner         (winner),
    .cePS           (cePS),
    .ceSS           (ceSS),
    .game_en        (game_en),
    .game_clear     (game_clear),
    .winner_latched (winner_latched),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_screen   = 0;
    m_prev_btn = 1'b1;
    m_win      = 2'b00;
    m_ticks    = 0;
  endtask

  task automatic check_all(input string where);
    check({where, ":state"}, state, 2'(m_screen));
    check({where, ":cePS"}, {1'b0, cePS}, {1'b0, m_screen == 0});
    check({where, ":game_clear"}, {1'b0, game_clear}, {1'b0, m_screen == 1});
    check({where, ":game_en"}, {1'b0, game_en}, {1'b0, m_screen == 2});
    check({where, ":ceSS"}, {1'b0, ceSS}, {1'b0, m_screen == 3});
    check({where, ":winner_latched"}, winner_latched, m_win);
    check({where, ":screens_exclusive"}, {1'b0, cePS & ceSS}, 2'b00);
    check({where, ":clear_single"}, {1'b0, prev_gc & game_clear}, 2'b00);
    prev_gc = game_clear;
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare 1 time unit later.
  task automatic step(input string where);
    logic rise;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      rise = start_btn && !m_prev_btn;
      case (m_screen)
        0: if (rise) begin m_screen = 1; m_win = 2'b00; end
        1: m_screen = 2;
        2: if (game_over) begin m_screen = 3; m_win = winner; m_ticks = 0; end
        default: begin
          if (rise) begin
            m_screen = 1;
            m_win    = 2'b00;
          end else if (frame_tick) begin
            m_ticks++;
            if (m_ticks == int'(HOLD)) m_screen = 0;
          end
        end
      endcase
      m_prev_btn = start_btn;
    end
    #1;
    check_all(where);
  endtask

  initial begin
    // Reset with the button held high.
    model_reset();
    step("reset0");
    step("reset1");
    reset_n = 1'b1;
    step("held_after_reset0");
    step("held_after_reset1");
    start_btn = 1'b0;
    step("release");
    start_btn = 1'b1;
    step("press_clear");
    step("press_play");
    step("play_hold");

    // End of match, O wins; a coincident tick must not count.
    game_over = 1'b1; winner = 2'b10; frame_tick = 1'b1;
    step("enter_win");
    game_over = 1'b0; winner = 2'b01; frame_tick = 1'b0;
    step("win_idle");
    frame_tick = 1'b1; step("win_tick1");
    frame_tick = 1'b0; step("win_gap1");
    frame_tick = 1'b1; step("win_tick2");
    frame_tick = 1'b0; step("win_gap2");
    game_over = 1'b1;  step("win_ignore_go");
    game_over = 1'b0;
    frame_tick = 1'b1; step("win_tick3_present");
    frame_tick = 1'b0; step("present_keep_winner");

    // Second match, then rematch coincident with the final tick.
    start_btn = 1'b0; step("release2");
    start_btn = 1'b1; step("press2_clear");
    step("press2_play");
    game_over = 1'b1; winner = 2'b01;
    step("enter_win2");
    game_over = 1'b0;
    frame_tick = 1'b1; step("win2_tick1");
    frame_tick = 1'b1; step("win2_tick2");
    frame_tick = 1'b0; start_btn = 1'b0; step("win2_release");
    frame_tick = 1'b1; start_btn = 1'b1; step("rematch_vs_expiry");
    frame_tick = 1'b0; step("rematch_play");
    step("rematch_play2");

    // Asynchronous reset between edges, mid-PLAY.
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    step("in_reset");
    reset_n = 1'b1;
    step("after_reset_held");

    // Random run.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) start_btn = ~start_btn;
      game_over  = ($urandom_range(0, 3) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      winner     = 2'($urandom_range(0, 3));
      reset_n    = ($urandom_range(0, 149) != 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
